mux_arb_reg: RTL and testbench

- Parametrised successor of the datapath 2:1 mux: an N-input, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every port.
- Two modes: external-select, where the sel port picks the source as a plain mux does, or round-robin arbitration among the valid inputs.
- Sits between MIPS pipeline producers (e.g. ALU result, load data, PC+4 write-back sources) and a single consumer stage. It gives one cycle of latency and full throughput.

---
 rtl/mux_arb_pkg.sv | 9 +
 rtl/mux_arb_reg_rr_pick.sv | 22 ++
 rtl/mux_arb_reg.sv | 61 ++++++
 tb/tb_mux_arb_reg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and width helper for the registered arbitrating mux
package mux_arb_pkg;
  typedef enum logic {MODE_SEL, MODE_RR} mode_e;
  localparam int DEF_WIDTH = 5;
  typedef logic [DEF_WIDTH-1:0] word_t;
  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/mux_arb_reg_rr_pick.sv
// rr_pick: first valid channel after ptr, searching with wrap-around
module rr_pick #(
  parameter int N = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);
  // scan farthest-first so the nearest valid channel after ptr wins
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (valid[(int'(ptr) + k) % N]) begin
        idx = SW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-input registered mux with valid/ready and optional round-robin
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int N = 4,
  parameter int RR_MODE = 0,
  parameter int SW = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready
);
  localparam mode_e MODE = (RR_MODE != 0) ? MODE_RR : MODE_SEL;
  localparam int NS = 1 << SW;
  logic can_load, gnt_ok, load;
  logic [SW-1:0] gnt;
  logic [WIDTH-1:0] pick;
  assign can_load = !out_valid || out_ready;
  assign load = gnt_ok && can_load;
  assign in_ready = (load && !rst) ? N'(1) << gnt : '0;
  assign pick = gnt_ok ? in_data[int'(gnt)*WIDTH +: WIDTH] : '0;
  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] ptr;
      rr_pick #(.N(N), .SW(SW)) u_pick (
        .valid(in_valid),
        .ptr(ptr),
        .idx(gnt),
        .found(gnt_ok)
      );
      // pointer follows the last channel that actually transferred
      always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= SW'(N - 1);
        else if (load) ptr <= gnt;
    end else begin : g_sel
      logic [NS-1:0] valid_ext;
      assign valid_ext = NS'(in_valid);
      assign gnt = sel;
      assign gnt_ok = valid_ext[sel];
    end
  endgenerate
  // output register: load wins over drain, drain keeps data and source
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= pick;
      out_src <= gnt;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: directed checks of select mode, round-robin, backpressure and reset
module tb_mux_arb_reg;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;

  logic [3:0] v0 = '0, r0;
  logic [19:0] d0 = {5'd4, 5'd3, 5'd2, 5'd1};
  logic [1:0] s0 = '0, src0;
  logic ov0, ordy0 = 1'b0;
  logic [4:0] od0;

  logic [2:0] v1 = '0, r1;
  logic [14:0] d1 = {5'd7, 5'd6, 5'd5};
  logic [1:0] s1 = '0, src1;
  logic ov1, ordy1 = 1'b0;
  logic [4:0] od1;

  logic [3:0] v2 = '0, r2;
  logic [19:0] d2 = {5'd13, 5'd12, 5'd11, 5'd10};
  logic [1:0] s2 = '0, src2;
  logic ov2, ordy2 = 1'b0;
  logic [4:0] od2;

  mux_arb_reg #(.WIDTH(5), .N(4), .RR_MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(r0), .sel(s0),
    .out_valid(ov0), .out_data(od0), .out_src(src0), .out_ready(ordy0));
  mux_arb_reg #(.WIDTH(5), .N(3), .RR_MODE(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1), .sel(s1),
    .out_valid(ov1), .out_data(od1), .out_src(src1), .out_ready(ordy1));
  mux_arb_reg #(.WIDTH(5), .N(4), .RR_MODE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(r2), .sel(s2),
    .out_valid(ov2), .out_data(od2), .out_src(src2), .out_ready(ordy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    v0 = 4'b1111; s0 = 2'd2; ordy0 = 1'b1; v2 = 4'b1111; ordy2 = 1'b1;
    #1;
    checks++; if (r0 !== 4'b0000) begin errors++; $display("FAIL reset_ready0 got=%b exp=0000", r0); end
    checks++; if (r2 !== 4'b0000) begin errors++; $display("FAIL reset_ready2 got=%b exp=0000", r2); end
    tick();
    checks++; if ({ov0, src0, od0} !== 8'h00) begin errors++; $display("FAIL reset_out0 got=%h exp=00", {ov0, src0, od0}); end
    checks++; if ({ov2, src2, od2} !== 8'h00) begin errors++; $display("FAIL reset_out2 got=%h exp=00", {ov2, src2, od2}); end
    checks++; if ({ov1, src1, od1} !== 8'h00) begin errors++; $display("FAIL reset_out1 got=%h exp=00", {ov1, src1, od1}); end
    v0 = '0; v2 = '0;
    rst = 1'b0;
  endtask

  task automatic test_sel();
    v0 = 4'b1111; s0 = 2'd2; ordy0 = 1'b1;
    #1;
    checks++; if (r0 !== 4'b0100) begin errors++; $display("FAIL sel2_ready got=%b exp=0100", r0); end
    tick();
    checks++; if ({ov0, src0, od0} !== {1'b1, 2'd2, 5'd3}) begin errors++; $display("FAIL sel2_out got=%h exp=%h", {ov0, src0, od0}, {1'b1, 2'd2, 5'd3}); end
    checks++; if (r0 !== 4'b0100) begin errors++; $display("FAIL sel2_ready_after got=%b exp=0100", r0); end
    s0 = 2'd0;
    #1;
    checks++; if (r0 !== 4'b0001) begin errors++; $display("FAIL sel0_ready got=%b exp=0001", r0); end
    tick();
    checks++; if ({ov0, src0, od0} !== {1'b1, 2'd0, 5'd1}) begin errors++; $display("FAIL drain_load_out got=%h exp=%h", {ov0, src0, od0}, {1'b1, 2'd0, 5'd1}); end
  endtask

  task automatic test_no_grant();
    v0 = 4'b0000; s0 = 2'd1;
    #1;
    checks++; if (r0 !== 4'b0000) begin errors++; $display("FAIL nogrant_ready got=%b exp=0000", r0); end
    tick();
    checks++; if ({ov0, src0, od0} !== {1'b0, 2'd0, 5'd1}) begin errors++; $display("FAIL nogrant_drain got=%h exp=%h", {ov0, src0, od0}, {1'b0, 2'd0, 5'd1}); end
    v1 = 3'b111; s1 = 2'd3; ordy1 = 1'b1;
    #1;
    checks++; if (r1 !== 3'b000) begin errors++; $display("FAIL sel_oob_ready got=%b exp=000", r1); end
    tick();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL sel_oob_valid got=%b exp=0", ov1); end
    s1 = 2'd0;
    #1;
    checks++; if (r1 !== 3'b001) begin errors++; $display("FAIL n3_sel0_ready got=%b exp=001", r1); end
    tick();
    checks++; if ({ov1, src1, od1} !== {1'b1, 2'd0, 5'd5}) begin errors++; $display("FAIL n3_sel0_out got=%h exp=%h", {ov1, src1, od1}, {1'b1, 2'd0, 5'd5}); end
    v1 = '0;
  endtask

  task automatic test_rr_all();
    logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [4:0] dat [6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd10, 5'd11};
    v2 = 4'b1111; ordy2 = 1'b1;
    #1;
    checks++; if (r2 !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got=%b exp=0001", r2); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({ov2, src2, od2} !== {1'b1, seq[k], dat[k]}) begin
        errors++; $display("FAIL rr_all_%0d got=%h exp=%h", k, {ov2, src2, od2}, {1'b1, seq[k], dat[k]});
      end
    end
  endtask

  task automatic test_rr_pair();
    logic [1:0] seq [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
    logic [4:0] dat [4] = '{5'd13, 5'd11, 5'd13, 5'd11};
    v2 = 4'b1010;
    #1;
    checks++; if (r2 !== 4'b1000) begin errors++; $display("FAIL rr_pair_ready got=%b exp=1000", r2); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({ov2, src2, od2} !== {1'b1, seq[k], dat[k]}) begin
        errors++; $display("FAIL rr_pair_%0d got=%h exp=%h", k, {ov2, src2, od2}, {1'b1, seq[k], dat[k]});
      end
    end
  endtask

  task automatic test_backpressure();
    v2 = 4'b1111; ordy2 = 1'b0;
    #1;
    checks++; if (r2 !== 4'b0000) begin errors++; $display("FAIL bp_ready got=%b exp=0000", r2); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({ov2, src2, od2} !== {1'b1, 2'd1, 5'd11}) begin
        errors++; $display("FAIL bp_hold_%0d got=%h exp=%h", k, {ov2, src2, od2}, {1'b1, 2'd1, 5'd11});
      end
      checks++; if (r2 !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d got=%b exp=0000", k, r2); end
    end
    ordy2 = 1'b1;
    #1;
    checks++; if (r2 !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b exp=0100", r2); end
    tick();
    checks++; if ({ov2, src2, od2} !== {1'b1, 2'd2, 5'd12}) begin errors++; $display("FAIL bp_release_out got=%h exp=%h", {ov2, src2, od2}, {1'b1, 2'd2, 5'd12}); end
    v2 = 4'b0000;
    tick();
    checks++; if ({ov2, src2, od2} !== {1'b0, 2'd2, 5'd12}) begin errors++; $display("FAIL bp_drain got=%h exp=%h", {ov2, src2, od2}, {1'b0, 2'd2, 5'd12}); end
  endtask

  task automatic test_async_reset();
    v2 = 4'b1111; ordy2 = 1'b1;
    v0 = 4'b1111; s0 = 2'd3; ordy0 = 1'b1;
    tick();
    checks++; if ({ov2, src2, od2} !== {1'b1, 2'd3, 5'd13}) begin errors++; $display("FAIL pre_rst_out2 got=%h exp=%h", {ov2, src2, od2}, {1'b1, 2'd3, 5'd13}); end
    checks++; if ({ov0, src0, od0} !== {1'b1, 2'd3, 5'd4}) begin errors++; $display("FAIL pre_rst_out0 got=%h exp=%h", {ov0, src0, od0}, {1'b1, 2'd3, 5'd4}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({ov2, src2, od2} !== 8'h00) begin errors++; $display("FAIL async_rst_out2 got=%h exp=00", {ov2, src2, od2}); end
    checks++; if ({ov0, src0, od0} !== 8'h00) begin errors++; $display("FAIL async_rst_out0 got=%h exp=00", {ov0, src0, od0}); end
    checks++; if (r2 !== 4'b0000) begin errors++; $display("FAIL async_rst_ready got=%b exp=0000", r2); end
    #3 rst = 1'b0;
    #1;
    checks++; if (r2 !== 4'b0001) begin errors++; $display("FAIL post_rst_ready got=%b exp=0001", r2); end
    tick();
    checks++; if ({ov2, src2, od2} !== {1'b1, 2'd0, 5'd10}) begin errors++; $display("FAIL post_rst_out got=%h exp=%h", {ov2, src2, od2}, {1'b1, 2'd0, 5'd10}); end
  endtask

  initial begin
    test_reset();
    test_sel();
    test_no_grant();
    test_rr_all();
    test_rr_pair();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
